cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_arb_pkg.sv | 21 ++
 rtl/cache_mem_arbiter_if.sv | 45 ++++
 rtl/word_counter.sv | 26 ++
 rtl/cache_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the cache/memory arbiter.
package cache_arb_pkg;

    // Default number of 16-bit words in one cache block.
    localparam int BLK_WORDS_DEF = 8;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FILL_I = 2'd2,
        FILL_D = 2'd3
    } arbStateT;

    // Side that received the most recent grant.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gntSideT;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Request, memory and fill signals shared by the arbiter and its environment.
interface cache_mem_arbiter_if;

    // Cache-side requests
    logic        icache_miss;
    logic [15:0] icache_addr;
    logic        dcache_miss;
    logic        dcache_wr;
    logic [15:0] dcache_addr;
    logic [15:0] dcache_wdata;

    // Main-memory port
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;

    // Fill path and completion back to the caches
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        fill_we_i;
    logic        fill_we_d;
    logic        i_done;
    logic        d_done;
    logic        busy;

    // Arbiter view: takes requests and read data, drives memory and fills.
    modport master (
        input  icache_miss, icache_addr, dcache_miss, dcache_wr, dcache_addr, dcache_wdata,
        input  mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word, fill_we_i, fill_we_d, i_done, d_done, busy
    );

    // Environment view: caches plus main memory.
    modport slave (
        output icache_miss, icache_addr, dcache_miss, dcache_wr, dcache_addr, dcache_wdata,
        output mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word, fill_we_i, fill_we_d, i_done, d_done, busy
    );

endinterface

// File: rtl/word_counter.sv
// Modulo-MOD counter with synchronous clear and increment enable.
module word_counter #(
    parameter int MOD = 8,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // Count up on inc, wrap after MOD-1; clear has priority over inc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-through stores
// onto a single pipelined main-memory port.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int BLK_WORDS = BLK_WORDS_DEF
) (
    input logic          clk,
    input logic          rst,
    cache_mem_arbiter_if.master bus
);

    localparam int            CW   = $clog2(BLK_WORDS);
    localparam logic [CW-1:0] LAST = CW'(BLK_WORDS - 1);

    arbStateT      stateReg, stateNext;
    gntSideT       lastGntReg, lastGntNext;
    logic [15:0]   addrReg, addrNext;
    logic [15:0]   wdataReg, wdataNext;
    logic          issuingReg, issuingNext;
    logic          iDoneReg, iDoneNext;
    logic          dDoneReg, dDoneNext;

    logic          cntClr;
    logic          issueInc;
    logic          retInc;
    logic [CW-1:0] issueCnt;
    logic [CW-1:0] retCnt;

    logic          memEn;
    logic          memWr;
    logic [15:0]   memAddr;
    logic [15:0]   memWdata;
    logic          fillWeI;
    logic          fillWeD;

    // Word index of the next read to issue within the current block.
    word_counter #(.MOD(BLK_WORDS), .W(CW)) issueCounter (
        .clk (clk),
        .rst (rst),
        .clr (cntClr),
        .inc (issueInc),
        .cnt (issueCnt)
    );

    // Word index of the next read return expected within the current block.
    word_counter #(.MOD(BLK_WORDS), .W(CW)) returnCounter (
        .clk (clk),
        .rst (rst),
        .clr (cntClr),
        .inc (retInc),
        .cnt (retCnt)
    );

    // State and latched-request registers; reset abandons any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg   <= IDLE;
            lastGntReg <= GNT_I;
            addrReg    <= '0;
            wdataReg   <= '0;
            issuingReg <= 1'b0;
            iDoneReg   <= 1'b0;
            dDoneReg   <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            lastGntReg <= lastGntNext;
            addrReg    <= addrNext;
            wdataReg   <= wdataNext;
            issuingReg <= issuingNext;
            iDoneReg   <= iDoneNext;
            dDoneReg   <= dDoneNext;
        end
    end

    // Grant selection, read issue and return bookkeeping.
    always_comb begin
        stateNext   = stateReg;
        lastGntNext = lastGntReg;
        addrNext    = addrReg;
        wdataNext   = wdataReg;
        issuingNext = issuingReg;
        iDoneNext   = 1'b0;
        dDoneNext   = 1'b0;
        cntClr      = 1'b0;
        issueInc    = 1'b0;
        retInc      = 1'b0;
        memEn       = 1'b0;
        memWr       = 1'b0;
        memAddr     = '0;
        memWdata    = '0;
        fillWeI     = 1'b0;
        fillWeD     = 1'b0;

        case (stateReg)
            IDLE: begin
                // A pending I-miss jumps the queue right after a D-side grant,
                // so a stream of stores cannot starve instruction fetch.
                if (lastGntReg == GNT_D && bus.icache_miss) begin
                    stateNext   = FILL_I;
                    lastGntNext = GNT_I;
                    addrNext    = bus.icache_addr;
                    issuingNext = 1'b1;
                    cntClr      = 1'b1;
                end else if (bus.dcache_wr) begin
                    stateNext   = WRITE;
                    lastGntNext = GNT_D;
                    addrNext    = bus.dcache_addr;
                    wdataNext   = bus.dcache_wdata;
                end else if (bus.dcache_miss) begin
                    stateNext   = FILL_D;
                    lastGntNext = GNT_D;
                    addrNext    = bus.dcache_addr;
                    issuingNext = 1'b1;
                    cntClr      = 1'b1;
                end else if (bus.icache_miss) begin
                    stateNext   = FILL_I;
                    lastGntNext = GNT_I;
                    addrNext    = bus.icache_addr;
                    issuingNext = 1'b1;
                    cntClr      = 1'b1;
                end
            end

            WRITE: begin
                memEn     = 1'b1;
                memWr     = 1'b1;
                memAddr   = addrReg;
                memWdata  = wdataReg;
                stateNext = IDLE;
            end

            FILL_I, FILL_D: begin
                // Issue the whole block back to back, word-aligned addresses.
                if (issuingReg) begin
                    memEn    = 1'b1;
                    memAddr  = {addrReg[15:CW+1], issueCnt, 1'b0};
                    issueInc = 1'b1;
                    if (issueCnt == LAST) begin
                        issuingNext = 1'b0;
                    end
                end
                // Returns arrive in issue order, so a simple counter names the word.
                if (bus.mem_valid) begin
                    retInc  = 1'b1;
                    fillWeI = (stateReg == FILL_I);
                    fillWeD = (stateReg == FILL_D);
                    if (retCnt == LAST) begin
                        stateNext = IDLE;
                        iDoneNext = (stateReg == FILL_I);
                        dDoneNext = (stateReg == FILL_D);
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.mem_en    = memEn;
    assign bus.mem_wr    = memWr;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.fill_data = bus.mem_rdata;
    assign bus.fill_word = 3'(retCnt);
    assign bus.fill_we_i = fillWeI;
    assign bus.fill_we_d = fillWeD;
    assign bus.i_done    = iDoneReg;
    // Stores complete in their single WRITE cycle; fills complete a cycle later.
    assign bus.d_done    = (stateReg == WRITE) | dDoneReg;
    assign bus.busy      = (stateReg != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: table of single/dual request
// transactions plus hand-written fairness, stray-return and reset sequences.
module tb_cache_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_mem_arbiter_if bus();

    cache_mem_arbiter #(.BLK_WORDS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        int          cyc;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } accT;

    typedef struct {
        logic side;   // 0 = I, 1 = D
        int   cyc;
    } doneT;

    typedef struct {
        logic        dwr;
        logic        dmiss;
        logic        imiss;
        logic [15:0] daddr;
        logic [15:0] iaddr;
        logic [15:0] wdata;
        int          lat;
        logic        expWr;
        logic [15:0] expAddr;
        logic [15:0] expWdata;
        int          expLat;
        int          expDones;
        logic        expSide0;
        logic        expSide1;
        int          expFillI;
        int          expFillD;
    } vecT;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          memLat = 1;
    int          weCnt = 0;
    int          weI = 0;
    int          weD = 0;
    logic        holdDwr = 1'b0;
    logic        sv [64];
    logic [15:0] sd [64];
    logic [15:0] sa [64];
    logic [15:0] curAddr;
    accT         accQ[$];
    doneT        doneQ[$];
    vecT         vecs [6];

    function automatic logic [15:0] memFn(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // One clock: drive scheduled returns after the edge, sample at the falling edge.
    task automatic tick();
        int   s;
        accT  a;
        doneT d;
        @(posedge clk);
        cyc++;
        #1;
        s = cyc % 64;
        bus.mem_valid = sv[s];
        bus.mem_rdata = sv[s] ? sd[s] : 16'h0000;
        curAddr = sa[s];
        sv[s] = 1'b0;
        @(negedge clk);
        if (bus.mem_en) begin
            a.cyc = cyc; a.wr = bus.mem_wr; a.addr = bus.mem_addr; a.data = bus.mem_wdata;
            accQ.push_back(a);
            if (!bus.mem_wr) begin
                s = (cyc + memLat) % 64;
                sv[s] = 1'b1;
                sd[s] = memFn(bus.mem_addr);
                sa[s] = bus.mem_addr;
            end
        end
        if (bus.fill_we_i || bus.fill_we_d) begin
            weCnt++;
            if (bus.fill_we_i) weI++;
            if (bus.fill_we_d) weD++;
            chk("fill_on_valid", 32'(bus.mem_valid), 32'd1);
            chk("fill_word", 32'(bus.fill_word), 32'((curAddr >> 1) & 16'h0007));
            chk("fill_data", 32'(bus.fill_data), 32'(memFn(curAddr)));
            chk("fill_we_onehot", 32'(bus.fill_we_i & bus.fill_we_d), 32'd0);
        end
        if (bus.i_done) begin
            d.side = 1'b0; d.cyc = cyc; doneQ.push_back(d);
            bus.icache_miss = 1'b0;
        end
        if (bus.d_done) begin
            d.side = 1'b1; d.cyc = cyc; doneQ.push_back(d);
            bus.dcache_miss = 1'b0;
            if (!holdDwr) bus.dcache_wr = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecT  t;
        int   g;
        int   rdIdx;
        int   bad;
        int   prevCyc;
        int   expAcc;
        logic [15:0] base;

        //               dwr   dmiss imiss daddr    iaddr    wdata   lat expWr expAddr  expWdata lat dn s0    s1    fI fD
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h00A4, 16'h0000, 16'hBEEF, 4, 1'b1, 16'h00A4, 16'hBEEF, 1,  1, 1'b1, 1'b0, 0, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h1236, 16'h0000, 4, 1'b0, 16'h1230, 16'h0000, 13, 1, 1'b0, 1'b0, 8, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h8000, 16'h0040, 16'h0000, 2, 1'b0, 16'h8000, 16'h0000, 11, 2, 1'b1, 1'b0, 8, 8};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 16'h0102, 16'h0200, 16'h1234, 1, 1'b1, 16'h0102, 16'h1234, 1,  2, 1'b1, 1'b0, 8, 0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h7FFF, 16'h0000, 16'h0000, 3, 1'b0, 16'h7FF0, 16'h0000, 12, 1, 1'b1, 1'b0, 0, 8};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'hFFFF, 16'hA5A5, 1, 1'b0, 16'hFFF0, 16'h0000, 10, 2, 1'b0, 1'b1, 8, 0};

        foreach (sv[i]) begin sv[i] = 1'b0; sd[i] = 16'h0000; sa[i] = 16'h0000; end
        rst = 1'b1;
        bus.icache_miss = 1'b0; bus.icache_addr = 16'h0000;
        bus.dcache_miss = 1'b0; bus.dcache_wr = 1'b0;
        bus.dcache_addr = 16'h0000; bus.dcache_wdata = 16'h0000;
        bus.mem_rdata = 16'h0000; bus.mem_valid = 1'b0;

        // Reset state
        tick();
        bus.mem_rdata = 16'h1357;
        #1;
        chk("reset_ctrl", 32'({bus.mem_en, bus.mem_wr, bus.fill_we_i, bus.fill_we_d,
                               bus.i_done, bus.d_done, bus.busy}), 32'd0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("reset_fill_word", 32'(bus.fill_word), 32'd0);
        chk("reset_fill_data", 32'(bus.fill_data), 32'h1357);
        rst = 1'b0;
        tick();

        // Table-driven transactions
        for (int v = 0; v < 6; v++) begin
            t = vecs[v];
            accQ.delete(); doneQ.delete();
            weI = 0; weD = 0;
            memLat = t.lat;
            bus.dcache_wr = t.dwr; bus.dcache_miss = t.dmiss; bus.icache_miss = t.imiss;
            bus.dcache_addr = t.daddr; bus.icache_addr = t.iaddr; bus.dcache_wdata = t.wdata;
            g = cyc;
            for (int k = 0; k < 200 && doneQ.size() < t.expDones; k++) tick();
            repeat (4) tick();

            expAcc = (t.dwr ? 1 : 0) + (t.dmiss ? 8 : 0) + (t.imiss ? 8 : 0);
            chk("done_count", 32'(doneQ.size()), 32'(t.expDones));
            chk("access_count", 32'(accQ.size()), 32'(expAcc));
            if (doneQ.size() > 0) begin
                chk("done0_side", 32'(doneQ[0].side), 32'(t.expSide0));
                chk("done0_latency", 32'(doneQ[0].cyc - g), 32'(t.expLat));
            end
            if (t.expDones == 2 && doneQ.size() > 1) begin
                chk("done1_side", 32'(doneQ[1].side), 32'(t.expSide1));
            end
            if (accQ.size() > 0) begin
                chk("first_access_cycle", 32'(accQ[0].cyc - g), 32'd1);
                chk("first_access_wr", 32'(accQ[0].wr), 32'(t.expWr));
                chk("first_access_addr", 32'(accQ[0].addr), 32'(t.expAddr));
                if (t.expWr) chk("first_access_wdata", 32'(accQ[0].data), 32'(t.expWdata));
            end
            chk("fills_i", 32'(weI), 32'(t.expFillI));
            chk("fills_d", 32'(weD), 32'(t.expFillD));

            rdIdx = 0; bad = 0; prevCyc = 0; base = 16'h0000;
            foreach (accQ[j]) begin
                if (!accQ[j].wr) begin
                    if (rdIdx % 8 == 0) begin
                        base = accQ[j].addr & 16'hFFF0;
                        if (!((t.dmiss && base == (t.daddr & 16'hFFF0)) ||
                              (t.imiss && base == (t.iaddr & 16'hFFF0)))) bad++;
                    end else if (accQ[j].cyc != prevCyc + 1) begin
                        bad++;
                    end
                    if (accQ[j].addr != (base | 16'(2 * (rdIdx % 8)))) bad++;
                    prevCyc = accQ[j].cyc;
                    rdIdx++;
                end
            end
            chk("read_pattern", 32'(bad), 32'd0);
            $display("vec %0d: accesses=%0d dones=%0d fills_i=%0d fills_d=%0d",
                     v, accQ.size(), doneQ.size(), weI, weD);
        end

        // Stray return while idle
        accQ.delete();
        weCnt = 0;
        sv[(cyc + 1) % 64] = 1'b1;
        sd[(cyc + 1) % 64] = 16'h5555;
        sa[(cyc + 1) % 64] = 16'h0000;
        tick();
        chk("stray_fill_we", 32'({bus.fill_we_i, bus.fill_we_d}), 32'd0);
        chk("stray_busy", 32'(bus.busy), 32'd0);
        chk("stray_fill_data", 32'(bus.fill_data), 32'h5555);
        tick();
        chk("stray_stays_idle", 32'(bus.busy), 32'd0);
        chk("stray_fill_word", 32'(bus.fill_word), 32'd0);
        chk("stray_no_access", 32'(accQ.size()), 32'd0);
        chk("stray_we_count", 32'(weCnt), 32'd0);
        $display("stray: busy=%0d accesses=%0d", bus.busy, accQ.size());

        // Fairness: stores held continuously against a pending I-miss
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        accQ.delete(); doneQ.delete();
        holdDwr = 1'b1;
        memLat = 1;
        bus.dcache_wr = 1'b1; bus.dcache_addr = 16'h0300; bus.dcache_wdata = 16'h1111;
        bus.icache_miss = 1'b1; bus.icache_addr = 16'h0400;
        g = cyc;
        for (int k = 0; k < 100 && doneQ.size() < 3; k++) tick();
        holdDwr = 1'b0;
        bus.dcache_wr = 1'b0;
        repeat (4) tick();
        chk("fair_done_count", 32'(doneQ.size()), 32'd3);
        if (doneQ.size() >= 3) begin
            chk("fair_done0_side", 32'(doneQ[0].side), 32'd1);
            chk("fair_done1_side", 32'(doneQ[1].side), 32'd0);
            chk("fair_done2_side", 32'(doneQ[2].side), 32'd1);
        end
        chk("fair_access_count", 32'(accQ.size()), 32'd10);
        if (accQ.size() >= 10) begin
            chk("fair_w0", 32'({accQ[0].wr, accQ[0].addr}), 32'h1_0300);
            chk("fair_w0_data", 32'(accQ[0].data), 32'h1111);
            chk("fair_i_first", 32'({accQ[1].wr, accQ[1].addr}), 32'h0_0400);
            chk("fair_i_wait", 32'(accQ[1].cyc - g), 32'd3);
            chk("fair_w1", 32'({accQ[9].wr, accQ[9].addr}), 32'h1_0300);
            chk("fair_w1_cycle", 32'(accQ[9].cyc - g), 32'd13);
        end
        $display("fairness: accesses=%0d dones=%0d", accQ.size(), doneQ.size());

        // Reset after the third fill return
        accQ.delete(); doneQ.delete();
        weCnt = 0;
        memLat = 8;
        bus.icache_miss = 1'b1; bus.icache_addr = 16'h2000;
        for (int k = 0; k < 100 && weCnt < 3; k++) tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", 32'({bus.mem_en, bus.mem_wr, bus.fill_we_i, bus.fill_we_d,
                                 bus.i_done, bus.d_done, bus.busy}), 32'd0);
        chk("rst_mid_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mid_fill_word", 32'(bus.fill_word), 32'd0);
        chk("rst_mid_fill_data", 32'(bus.fill_data), 32'(bus.mem_rdata));
        bus.icache_miss = 1'b0;
        tick();
        rst = 1'b0;
        repeat (12) tick();
        chk("rst_we_count", 32'(weCnt), 32'd3);
        chk("rst_no_done", 32'(doneQ.size()), 32'd0);
        chk("rst_reads_issued", 32'(accQ.size()), 32'd8);
        chk("rst_idle", 32'(bus.busy), 32'd0);
        $display("reset-mid-fill: fills=%0d dones=%0d", weCnt, doneQ.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
